// File: rtl/demux_sched_pkg.sv
// -----------------------------------------------------------------------------
// demux_sched_pkg
// Shared definitions for the demux_sched scheduler slice.
//   state_t : holding-register state (ST_EMPTY = free, ST_SEND = word held)
//   sel_w() : width of a channel index for a given channel count
// No ports (package).
// -----------------------------------------------------------------------------
package demux_sched_pkg;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_SEND  = 1'b1
    } state_t;

    // Channel-index width; SIZE is always >= 2, the guard only keeps the
    // helper well-defined for degenerate arguments.
    function automatic int sel_w(input int size);
        return (size > 1) ? $clog2(size) : 1;
    endfunction

endpackage

// File: rtl/demux_sched_demux.sv
// -----------------------------------------------------------------------------
// demux
// Lane fan-out: places data_i on lane sel_i of a flat SIZE*WIDTH bus when
// en_i is high; every other lane (and all lanes when en_i is low) reads 0.
// Ports:
//   en_i   [1]           drive enable
//   sel_i  [SEL_W]       destination lane
//   data_i [WIDTH]       word to place
//   data_o [SIZE*WIDTH]  lane k = bits [k*WIDTH +: WIDTH]
// -----------------------------------------------------------------------------
module demux
    import demux_sched_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SIZE  = 8,
    parameter int SEL_W = sel_w(SIZE)
) (
    input  logic                    en_i,
    input  logic [SEL_W-1:0]        sel_i,
    input  logic [WIDTH-1:0]        data_i,
    output logic [SIZE*WIDTH-1:0]   data_o
);

    always_comb begin
        data_o = '0;
        for (int k = 0; k < SIZE; k++) begin
            if (en_i && (sel_i == SEL_W'(k))) begin
                data_o[k*WIDTH +: WIDTH] = data_i;
            end
        end
    end

endmodule

// File: rtl/demux_sched_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational rotate-priority picker: returns the first set request bit
// found when scanning start_i, start_i+1, ... (mod SIZE).
// Ports:
//   req_i   [SIZE]  request vector
//   start_i [SEL_W] index where the scan begins (must be < SIZE)
//   idx_o   [SEL_W] winning index (0 when no request)
//   hit_o   [1]     at least one request bit set
// -----------------------------------------------------------------------------
module rr_pick
    import demux_sched_pkg::*;
#(
    parameter int SIZE  = 8,
    parameter int SEL_W = sel_w(SIZE)
) (
    input  logic [SIZE-1:0]  req_i,
    input  logic [SEL_W-1:0] start_i,
    output logic [SEL_W-1:0] idx_o,
    output logic             hit_o
);

    logic [SEL_W-1:0] k;

    // Walk offsets from the far end back to offset 0 so the nearest
    // requester (smallest offset from start_i) is the last one written.
    always_comb begin
        idx_o = '0;
        hit_o = 1'b0;
        k     = '0;
        for (int off = SIZE - 1; off >= 0; off--) begin
            k = SEL_W'((int'(start_i) + off) % SIZE);
            if (req_i[k]) begin
                idx_o = k;
                hit_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/demux_sched.sv
// -----------------------------------------------------------------------------
// demux_sched
// Round-robin scheduler spreading one valid/ready stream over SIZE output
// channels through a one-entry holding register. The destination is fixed
// when the word is loaded: first channel from the rotating pointer that is
// both enabled and ready, otherwise the first enabled one.
//
// Handshake: a word moves on a port when its valid and ready are both high
// at a rising clock edge; valid never depends on ready, and once raised a
// valid (and its data and lane) holds until that transfer happens.
//
// Ports:
//   iClk, iRst        clock, asynchronous active-high reset
//   iValid/oReady     input stream handshake (oReady never looks at iValid)
//   iData  [WIDTH]    input word
//   iMask  [SIZE]     channel enable for new grants
//   oValid [SIZE]     one-hot pending word per channel
//   iReady [SIZE]     per-channel consumer ready
//   oData  [SIZE*WIDTH] lane k = bits [k*WIDTH +: WIDTH], only granted lane non-zero
//   oSel   [$clog2(SIZE)] granted channel index
// Optional (macro DEMUX_SCHED_CNT_EN):
//   iClrCnt            clear all drain counters (wins over an increment)
//   oCount [SIZE*CNT_WIDTH] lane k = number of drains to channel k, wrapping
// -----------------------------------------------------------------------------
module demux_sched
    import demux_sched_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int SIZE      = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                      iClk,
    input  logic                      iRst,
    input  logic                      iValid,
    output logic                      oReady,
    input  logic [WIDTH-1:0]          iData,
    input  logic [SIZE-1:0]           iMask,
    output logic [SIZE-1:0]           oValid,
    input  logic [SIZE-1:0]           iReady,
    output logic [SIZE*WIDTH-1:0]     oData,
    output logic [$clog2(SIZE)-1:0]   oSel
`ifdef DEMUX_SCHED_CNT_EN
    ,
    input  logic                      iClrCnt,
    output logic [SIZE*CNT_WIDTH-1:0] oCount
`endif
);

    localparam int SEL_W = sel_w(SIZE);

    state_t           state_q, state_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [WIDTH-1:0] data_q, data_d;

    logic             drain;
    logic             load;
    logic [SEL_W-1:0] idx_rdy, idx_any, pick_sel, pick_next;
    logic             hit_rdy, hit_any;

    // Preferred pick: enabled and ready right now.
    rr_pick #(.SIZE(SIZE), .SEL_W(SEL_W)) u_pick_rdy (
        .req_i   (iMask & iReady),
        .start_i (ptr_q),
        .idx_o   (idx_rdy),
        .hit_o   (hit_rdy)
    );

    // Fallback pick: enabled only. Its hit doubles as "any channel enabled".
    rr_pick #(.SIZE(SIZE), .SEL_W(SEL_W)) u_pick_any (
        .req_i   (iMask),
        .start_i (ptr_q),
        .idx_o   (idx_any),
        .hit_o   (hit_any)
    );

    assign pick_sel  = hit_rdy ? idx_rdy : idx_any;
    assign pick_next = (pick_sel == SEL_W'(SIZE - 1)) ? '0 : pick_sel + 1'b1;

    assign drain  = (state_q == ST_SEND) && iReady[sel_q];
    assign oReady = hit_any && ((state_q == ST_EMPTY) || drain);
    assign load   = iValid && oReady;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        data_d  = data_q;
        if (load) begin
            // Also covers drain+load: the slot is refilled in the same cycle.
            state_d = ST_SEND;
            data_d  = iData;
            sel_d   = pick_sel;
            ptr_d   = pick_next;
        end else if (drain) begin
            state_d = ST_EMPTY;
            data_d  = '0;
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q <= ST_EMPTY;
            ptr_q   <= '0;
            sel_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        oValid = '0;
        if (state_q == ST_SEND) begin
            oValid[sel_q] = 1'b1;
        end
    end

    assign oSel = sel_q;

    demux #(.WIDTH(WIDTH), .SIZE(SIZE), .SEL_W(SEL_W)) u_demux (
        .en_i   (state_q == ST_SEND),
        .sel_i  (sel_q),
        .data_i (data_q),
        .data_o (oData)
    );

`ifdef DEMUX_SCHED_CNT_EN
    logic [SIZE*CNT_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (iClrCnt) begin
            cnt_d = '0;
        end else begin
            for (int k = 0; k < SIZE; k++) begin
                if (drain && (sel_q == SEL_W'(k))) begin
                    cnt_d[k*CNT_WIDTH +: CNT_WIDTH] = cnt_q[k*CNT_WIDTH +: CNT_WIDTH] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign oCount = cnt_q;
`else
    // Counter width has no meaning without the counters.
    logic unused_cnt_width;
    assign unused_cnt_width = ^CNT_WIDTH;
`endif

endmodule

// File: tb/tb_demux_sched.sv
// -----------------------------------------------------------------------------
// tb_demux_sched
// Self-checking bench for demux_sched (SIZE=4, WIDTH=32, CNT_WIDTH=2).
// A reference model tracks the held word, pointer and counters from the
// scheduling rules; accepted words go into an expected queue that a
// separate monitor pops whenever a channel drains.
// -----------------------------------------------------------------------------
module tb_demux_sched;

    localparam int WIDTH     = 32;
    localparam int SIZE      = 4;
    localparam int CNT_WIDTH = 2;
    localparam int SEL_W     = 2;

    logic                    iClk   = 1'b0;
    logic                    iRst   = 1'b1;
    logic                    iValid = 1'b0;
    logic                    oReady;
    logic [WIDTH-1:0]        iData  = '0;
    logic [SIZE-1:0]         iMask  = '0;
    logic [SIZE-1:0]         oValid;
    logic [SIZE-1:0]         iReady = '0;
    logic [SIZE*WIDTH-1:0]   oData;
    logic [SEL_W-1:0]        oSel;
`ifdef DEMUX_SCHED_CNT_EN
    logic                    iClrCnt = 1'b0;
    logic [SIZE*CNT_WIDTH-1:0] oCount;
`endif

    int n_cmp = 0;
    int n_err = 0;

    logic [SEL_W+WIDTH-1:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 iClk = ~iClk;

    demux_sched #(.WIDTH(WIDTH), .SIZE(SIZE), .CNT_WIDTH(CNT_WIDTH)) dut (
        .iClk   (iClk),
        .iRst   (iRst),
        .iValid (iValid),
        .oReady (oReady),
        .iData  (iData),
        .iMask  (iMask),
        .oValid (oValid),
        .iReady (iReady),
        .oData  (oData),
        .oSel   (oSel)
`ifdef DEMUX_SCHED_CNT_EN
        ,
        .iClrCnt(iClrCnt),
        .oCount (oCount)
`endif
    );

    task automatic check(input string name, input logic [SIZE*WIDTH-1:0] act,
                         input logic [SIZE*WIDTH-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit                     m_busy = 1'b0;
    int                     m_ptr  = 0;
    int                     m_sel  = 0;
    logic [WIDTH-1:0]       m_data = '0;
    int                     m_cnt[SIZE];

    always @(negedge iClk) begin
        logic [SIZE-1:0]       e_valid;
        logic [SIZE*WIDTH-1:0] e_data;
        logic [SIZE*CNT_WIDTH-1:0] e_cnt;
        bit                    drain, e_ready;
        int                    pick, k, old_sel;
        if (iRst) begin
            m_busy = 1'b0;
            m_ptr  = 0;
            m_sel  = 0;
            m_data = '0;
            exp_q.delete();
            for (int i = 0; i < SIZE; i++) m_cnt[i] = 0;
        end else begin
            e_valid = '0;
            e_data  = '0;
            if (m_busy) begin
                e_valid[m_sel] = 1'b1;
                e_data[m_sel*WIDTH +: WIDTH] = m_data;
            end
            drain   = m_busy && iReady[m_sel];
            e_ready = (iMask != '0) && (!m_busy || drain);
            check("oValid", oValid, e_valid);
            check("oData", oData, e_data);
            check("oSel", oSel, m_sel);
            check("oReady", oReady, e_ready);
`ifdef DEMUX_SCHED_CNT_EN
            for (int i = 0; i < SIZE; i++) e_cnt[i*CNT_WIDTH +: CNT_WIDTH] = CNT_WIDTH'(m_cnt[i]);
            check("oCount", oCount, e_cnt);
            old_sel = m_sel;
            if (iClrCnt) begin
                for (int i = 0; i < SIZE; i++) m_cnt[i] = 0;
            end else if (drain) begin
                m_cnt[old_sel] = (m_cnt[old_sel] + 1) % (1 << CNT_WIDTH);
            end
`else
            e_cnt   = '0;
            old_sel = 0;
`endif
            if (iValid && e_ready) begin
                pick = -1;
                for (int off = 0; off < SIZE; off++) begin
                    k = (m_ptr + off) % SIZE;
                    if (pick < 0 && iMask[k] && iReady[k]) pick = k;
                end
                for (int off = 0; off < SIZE; off++) begin
                    k = (m_ptr + off) % SIZE;
                    if (pick < 0 && iMask[k]) pick = k;
                end
                exp_q.push_back({SEL_W'(pick), iData});
                m_ptr  = (pick + 1) % SIZE;
                m_sel  = pick;
                m_data = iData;
                m_busy = 1'b1;
            end else if (drain) begin
                m_busy = 1'b0;
                m_data = '0;
            end
        end
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge iClk) begin
        logic [SEL_W+WIDTH-1:0] e;
        if (!iRst) begin
            for (int k = 0; k < SIZE; k++) begin
                if (oValid[k] && iReady[k]) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL drain_unexpected: channel %0d drained with no word expected", k);
                    end else begin
                        e = exp_q.pop_front();
                        check("drain_chan", k, e[WIDTH +: SEL_W]);
                        check("drain_data", oData[k*WIDTH +: WIDTH], e[WIDTH-1:0]);
                    end
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic step(input logic v, input logic [WIDTH-1:0] d,
                        input logic [SIZE-1:0] m, input logic [SIZE-1:0] r);
        iValid = v;
        iData  = d;
        iMask  = m;
        iReady = r;
        @(posedge iClk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        iMask = 4'hF;
        repeat (2) @(posedge iClk);
        #1;
        check("rst_oValid", oValid, '0);
        check("rst_oData", oData, '0);
        check("rst_oSel", oSel, '0);
        iRst = 1'b0;

        // Back-to-back round robin 0,1,2,3 and pointer wrap.
        for (int i = 0; i < 4; i++) step(1'b1, 32'hA0 + i, 4'hF, 4'hF);
        step(1'b0, '0, 4'hF, 4'hF);

        // Only channel 2 ready at load; hold one cycle, then drain.
        step(1'b1, 32'hB0, 4'hF, 4'b0100);
        step(1'b0, '0, 4'hF, 4'b0000);
        step(1'b0, '0, 4'hF, 4'b0100);

        // Move pointer to 1: words to channel 3 then 0.
        step(1'b1, 32'hC0, 4'hF, 4'hF);
        step(1'b1, 32'hC1, 4'hF, 4'hF);
        step(1'b0, '0, 4'hF, 4'hF);

        // Nobody ready: fallback grant channel 1, held for 5 cycles.
        step(1'b1, 32'hD1, 4'hF, 4'b0000);
        repeat (5) step(1'b0, '0, 4'hF, 4'b0000);
        step(1'b0, '0, 4'hF, 4'b0010);
        step(1'b0, '0, 4'hF, 4'b0000);

        // All channels masked: nothing accepted; then only channel 3 enabled.
        repeat (3) step(1'b1, 32'hE3, 4'h0, 4'hF);
        step(1'b1, 32'hE3, 4'b1000, 4'hF);
        step(1'b0, '0, 4'hF, 4'hF);

        // Async reset while channel 0 holds a word.
        step(1'b1, 32'hF0, 4'hF, 4'b0000);
        step(1'b0, '0, 4'hF, 4'b0000);
        iRst = 1'b1;
        #1;
        check("async_rst_oValid", oValid, '0);
        check("async_rst_oData", oData, '0);
        check("async_rst_oSel", oSel, '0);
        @(posedge iClk);
        #1;
        iRst = 1'b0;
        step(1'b1, 32'hF1, 4'hF, 4'hF);
        check("post_rst_chan0", oValid, 4'b0001);
        step(1'b0, '0, 4'hF, 4'hF);

`ifdef DEMUX_SCHED_CNT_EN
        // Five drains to channel 0 wrap a 2-bit counter to 1.
        iClrCnt = 1'b1;
        step(1'b0, '0, 4'hF, 4'hF);
        iClrCnt = 1'b0;
        for (int i = 0; i < 5; i++) step(1'b1, $urandom, 4'b0001, 4'b0001);
        step(1'b0, '0, 4'b0001, 4'b0001);
        check("cnt_wrap", oCount[CNT_WIDTH-1:0], 1);
        // Clear coinciding with a drain wins.
        step(1'b1, $urandom, 4'b0001, 4'b0000);
        iClrCnt = 1'b1;
        step(1'b0, '0, 4'b0001, 4'b0001);
        iClrCnt = 1'b0;
        check("cnt_clr_prio", oCount, '0);
`endif

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
`ifdef DEMUX_SCHED_CNT_EN
            iClrCnt = ($urandom_range(0, 15) == 0);
`endif
            step($urandom_range(0, 3) != 0, $urandom,
                 SIZE'($urandom_range(0, 15)), SIZE'($urandom_range(0, 15)));
        end
`ifdef DEMUX_SCHED_CNT_EN
        iClrCnt = 1'b0;
`endif

        // Flush whatever is still held.
        repeat (3) step(1'b0, '0, 4'hF, 4'hF);
        check("queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
